// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply unit: op encoding, FSM states, widths
// and the operand magnitude helper.
package hilo_pkg;

   localparam int DATA_W = 32;
   localparam int PROD_W = 64;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_MADD  = 3'd2,
      OP_MSUB  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MFHI  = 3'd6,
      OP_MFLO  = 3'd7
   } hilo_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_ACC  = 2'd2
   } hilo_state_t;

   // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
   function automatic logic [DATA_W-1:0] mag32(input logic signed [DATA_W-1:0] v);
      return v[DATA_W-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/hilo_mul_core.sv
// Iterative unsigned shift-add multiplier retiring BITS_PER_CYCLE multiplier
// bits per step into a 64-bit product register.
module hilo_mul_core
   import hilo_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [DATA_W-1:0] mcand_in,
   input  logic [DATA_W-1:0] mplier_in,
   output logic [PROD_W-1:0] product
);

   logic [PROD_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [PROD_W-1:0] partial_sum;

   always_comb begin
      partial_sum = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         if (mplier[k]) partial_sum = partial_sum + (mcand << k);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
      end else if (load) begin
         mcand   <= {{(PROD_W-DATA_W){1'b0}}, mcand_in};
         mplier  <= mplier_in;
         product <= '0;
      end else if (step) begin
         product <= product + partial_sum;
         mcand   <= mcand << BITS_PER_CYCLE;
         mplier  <= mplier >> BITS_PER_CYCLE;
      end
   end

endmodule

// File: rtl/hilo_mul_sequencer.sv
// MIPS HI/LO unit: MULT/MULTU/MADD/MSUB sequencing plus MTHI/MTLO/MFHI/MFLO.
// Define HILO_MADD_EN to build the MADD/MSUB accumulate path.
module hilo_mul_sequencer
   import hilo_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              op_valid,
   input  logic [2:0]        op_code,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   input  logic              flush,
   output logic              op_ready,
   output logic [DATA_W-1:0] mf_data,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              illegal_op
);

   localparam int ITERS = DATA_W / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef HILO_MADD_EN
   localparam bit MADD_BUILT = 1'b1;
`else
   localparam bit MADD_BUILT = 1'b0;
`endif

   hilo_state_t              state;
   hilo_op_t                 op_in;
   logic [CNT_W-1:0]         count;
   logic                     negate;
   logic                     accept, madd_op, is_mul_op, signed_op, illegal;
   logic [DATA_W-1:0]        mag_rs, mag_rt;
   logic [PROD_W-1:0]        product;
   logic signed [PROD_W-1:0] signed_product, result;

   function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] p, input logic neg);
      return neg ? (~p + 1'b1) : p;
   endfunction

   assign op_in     = hilo_op_t'(op_code);
   assign accept    = op_valid && op_ready;
   assign madd_op   = (op_in == OP_MADD) || (op_in == OP_MSUB);
   assign is_mul_op = (op_in == OP_MULT) || (op_in == OP_MULTU) || (MADD_BUILT && madd_op);
   assign signed_op = (op_in != OP_MULTU);
   assign illegal   = accept && madd_op && !MADD_BUILT;
   assign mag_rs    = signed_op ? mag32(rs_val) : rs_val;
   assign mag_rt    = signed_op ? mag32(rt_val) : rt_val;

   hilo_mul_core #(
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_core (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .load      (accept && is_mul_op),
      .step      ((state == ST_MUL) && !flush),
      .mcand_in  (mag_rs),
      .mplier_in (mag_rt),
      .product   (product)
   );

   assign signed_product = apply_sign(product, negate);

`ifdef HILO_MADD_EN
   hilo_op_t                 op;
   logic signed [PROD_W-1:0] hilo_acc;
   assign hilo_acc = {hi, lo};

   // Accumulation wraps modulo 2^64.
   always_comb begin
      case (op)
         OP_MADD: result = hilo_acc + signed_product;
         OP_MSUB: result = hilo_acc - signed_product;
         default: result = signed_product;
      endcase
   end
`else
   assign result = signed_product;
`endif

   always_comb begin
      mf_data = '0;
      if (accept && op_in == OP_MFHI) mf_data = hi;
      else if (accept && op_in == OP_MFLO) mf_data = lo;
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state      <= ST_IDLE;
         op_ready   <= 1'b1;
         count      <= '0;
         negate     <= 1'b0;
         illegal_op <= 1'b0;
         hi         <= '0;
         lo         <= '0;
`ifdef HILO_MADD_EN
         op         <= OP_MULT;
`endif
      end else begin
         illegal_op <= illegal;
         case (state)
            ST_IDLE: begin
               if (accept && is_mul_op) begin
                  state    <= ST_MUL;
                  op_ready <= 1'b0;
                  count    <= CNT_W'(ITERS);
                  negate   <= signed_op && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
`ifdef HILO_MADD_EN
                  op       <= op_in;
`endif
               end else if (accept && op_in == OP_MTHI) begin
                  hi <= rs_val;
               end else if (accept && op_in == OP_MTLO) begin
                  lo <= rs_val;
               end
            end
            ST_MUL: begin
               if (flush) begin
                  state    <= ST_IDLE;
                  op_ready <= 1'b1;
                  count    <= '0;
               end else begin
                  count <= count - 1'b1;
                  if (count == CNT_W'(1)) state <= ST_ACC;
               end
            end
            ST_ACC: begin
               // A flush landing on the completion edge discards the result.
               state    <= ST_IDLE;
               op_ready <= 1'b1;
               if (!flush) {hi, lo} <= result;
            end
            default: begin
               state    <= ST_IDLE;
               op_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// Self-checking bench for hilo_mul_sequencer (BITS_PER_CYCLE=1 and 4 instances).
module tb_hilo_mul_sequencer;

`ifdef HILO_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   localparam logic [2:0] C_MULT = 3'd0, C_MULTU = 3'd1, C_MADD = 3'd2, C_MSUB = 3'd3,
                          C_MTHI = 3'd4, C_MTLO = 3'd5, C_MFHI = 3'd6, C_MFLO = 3'd7;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        op_valid = 1'b0, flush = 1'b0;
   logic [2:0]  op_code = '0;
   logic [31:0] rs_val = '0, rt_val = '0;
   logic        op_ready, illegal_op;
   logic [31:0] mf_data, hi, lo;

   logic        v4 = 1'b0;
   logic [2:0]  c4 = '0;
   logic [31:0] a4 = '0, b4 = '0;
   logic        rdy4, ill4;
   logic [31:0] mf4, hi4, lo4;

   int errors = 0;
   int checks = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   always #5 Clk = ~Clk;

   hilo_mul_sequencer #(.BITS_PER_CYCLE(1)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .op_valid(op_valid), .op_code(op_code),
      .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .op_ready(op_ready),
      .mf_data(mf_data), .hi(hi), .lo(lo), .illegal_op(illegal_op));

   hilo_mul_sequencer #(.BITS_PER_CYCLE(4)) dut4 (
      .Clk(Clk), .Reset_n(Reset_n), .op_valid(v4), .op_code(c4),
      .rs_val(a4), .rt_val(b4), .flush(1'b0), .op_ready(rdy4),
      .mf_data(mf4), .hi(hi4), .lo(lo4), .illegal_op(ill4));

   // Architectural effect of one op on {HI,LO}, written with native arithmetic.
   function automatic logic [63:0] ref_hilo(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
      logic signed [63:0] sp;
      logic [63:0] up;
      sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      up = {32'b0, a} * {32'b0, b};
      case (op)
         C_MULT:  return sp;
         C_MULTU: return up;
         C_MADD:  return MADD_EN ? acc + sp : acc;
         C_MSUB:  return MADD_EN ? acc - sp : acc;
         C_MTHI:  return {a, acc[31:0]};
         C_MTLO:  return {acc[63:32], a};
         default: return acc;
      endcase
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      op_valid = 1'b1; op_code = op; rs_val = a; rt_val = b;
      while (!op_ready && n < 200) begin @(posedge Clk); #1; n++; end
      @(posedge Clk); #1;
      op_valid = 1'b0;
   endtask

   task automatic wait_ready(output int cycles);
      cycles = 0;
      while (!op_ready && cycles < 200) begin @(posedge Clk); #1; cycles++; end
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;
      m_hi = '0; m_lo = '0;
   endtask

   task automatic test_reset();
      checks += 5;
      if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", op_ready); end
      if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
      if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
      if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
      if (mf_data !== 32'h0) begin errors++; $display("FAIL reset_mf: got %h want 0", mf_data); end
   endtask

   task automatic test_multu();
      int busy;
      issue(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_ready(busy);
      m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001;
      checks += 3;
      if (busy != 33) begin errors++; $display("FAIL multu_busy: got %0d want 33", busy); end
      if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
      if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
   endtask

   task automatic test_mult_signed();
      int busy;
      issue(C_MULT, 32'hFFFFFFFF, 32'h00000002);
      wait_ready(busy);
      checks += 3;
      if (busy != 33) begin errors++; $display("FAIL mult_busy: got %0d want 33", busy); end
      if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
      if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
      issue(C_MULT, 32'h80000000, 32'h80000000);
      wait_ready(busy);
      m_hi = 32'h40000000; m_lo = 32'h0;
      checks++;
      if ({hi, lo} !== 64'h40000000_00000000) begin
         errors++; $display("FAIL mult_minint: got %h want 4000000000000000", {hi, lo});
      end
   endtask

   task automatic test_madd();
      int busy;
      logic [31:0] exp_lo;
      issue(C_MTLO, 32'd5, 32'd0);
      issue(C_MTHI, 32'd0, 32'd0);
      checks += 2;
      if (lo !== 32'd5) begin errors++; $display("FAIL mtlo: got %h want 00000005", lo); end
      if (hi !== 32'd0) begin errors++; $display("FAIL mthi: got %h want 0", hi); end
      issue(C_MADD, 32'd3, 32'd4);
      if (!MADD_EN) begin
         checks += 2;
         if (illegal_op !== 1'b1) begin errors++; $display("FAIL madd_illegal: got %b want 1", illegal_op); end
         if (op_ready !== 1'b1) begin errors++; $display("FAIL madd_ready: got %b want 1", op_ready); end
         @(posedge Clk); #1;
         checks++;
         if (illegal_op !== 1'b0) begin errors++; $display("FAIL madd_pulse_len: got %b want 0", illegal_op); end
      end else begin
         wait_ready(busy);
         checks++;
         if (busy != 33) begin errors++; $display("FAIL madd_busy: got %0d want 33", busy); end
      end
      exp_lo = MADD_EN ? 32'h11 : 32'h5;
      checks += 2;
      if (lo !== exp_lo) begin errors++; $display("FAIL madd_lo: got %h want %h", lo, exp_lo); end
      if (hi !== 32'h0) begin errors++; $display("FAIL madd_hi: got %h want 0", hi); end
      do_reset();
      issue(C_MSUB, 32'd1, 32'd1);
      if (MADD_EN) wait_ready(busy);
      else begin
         checks++;
         if (illegal_op !== 1'b1) begin errors++; $display("FAIL msub_illegal: got %b want 1", illegal_op); end
         @(posedge Clk); #1;
      end
      m_hi = MADD_EN ? 32'hFFFFFFFF : 32'h0;
      m_lo = m_hi;
      checks++;
      if ({hi, lo} !== {m_hi, m_lo}) begin
         errors++; $display("FAIL msub_result: got %h want %h", {hi, lo}, {m_hi, m_lo});
      end
   endtask

   task automatic test_back_to_back();
      int busy;
      logic [31:0] a, b;
      logic [63:0] e;
      a = $urandom; b = $urandom;
      e = ref_hilo(C_MULT, a, b, {m_hi, m_lo});
      issue(C_MULT, a, b);
      op_valid = 1'b1; op_code = C_MFHI; #1;
      checks += 2;
      if (op_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b want 0", op_ready); end
      if (mf_data !== 32'h0) begin errors++; $display("FAIL b2b_mf_idle: got %h want 0", mf_data); end
      wait_ready(busy);
      #1;
      checks += 2;
      if (busy != 33) begin errors++; $display("FAIL b2b_busy: got %0d want 33", busy); end
      if (mf_data !== e[63:32]) begin errors++; $display("FAIL b2b_mfhi: got %h want %h", mf_data, e[63:32]); end
      @(posedge Clk); #1;
      op_code = C_MFLO; #1;
      checks++;
      if (mf_data !== e[31:0]) begin errors++; $display("FAIL b2b_mflo: got %h want %h", mf_data, e[31:0]); end
      @(posedge Clk); #1;
      op_valid = 1'b0;
      {m_hi, m_lo} = e;
   endtask

   task automatic test_flush();
      issue(C_MTHI, 32'hA5A5A5A5, 32'h0);
      issue(C_MTLO, 32'h12345678, 32'h0);
      issue(C_MULT, $urandom, $urandom);
      repeat (9) begin @(posedge Clk); #1; end
      flush = 1'b1;
      @(posedge Clk); #1;
      flush = 1'b0;
      checks += 2;
      if (op_ready !== 1'b1) begin errors++; $display("FAIL flush_mul_ready: got %b want 1", op_ready); end
      if ({hi, lo} !== 64'hA5A5A5A5_12345678) begin
         errors++; $display("FAIL flush_mul_hilo: got %h want a5a5a5a512345678", {hi, lo});
      end
      issue(C_MULTU, 32'hFFFFFFFF, 32'h3);
      repeat (32) begin @(posedge Clk); #1; end
      checks++;
      if (op_ready !== 1'b0) begin errors++; $display("FAIL flush_acc_busy: got %b want 0", op_ready); end
      flush = 1'b1;
      @(posedge Clk); #1;
      flush = 1'b0;
      repeat (40) begin @(posedge Clk); #1; end
      checks += 2;
      if (op_ready !== 1'b1) begin errors++; $display("FAIL flush_acc_ready: got %b want 1", op_ready); end
      if ({hi, lo} !== 64'hA5A5A5A5_12345678) begin
         errors++; $display("FAIL flush_acc_hilo: got %h want a5a5a5a512345678", {hi, lo});
      end
      flush = 1'b1;
      issue(C_MTLO, 32'h77, 32'h0);
      flush = 1'b0;
      checks++;
      if (lo !== 32'h77) begin errors++; $display("FAIL flush_idle_mtlo: got %h want 00000077", lo); end
      m_hi = 32'hA5A5A5A5; m_lo = 32'h77;
   endtask

   task automatic test_reset_mid_mul();
      issue(C_MTHI, 32'h11111111, 32'h0);
      issue(C_MULTU, 32'hFFFF0000, 32'h0000FFFF);
      repeat (5) begin @(posedge Clk); #1; end
      Reset_n = 1'b0;
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      m_hi = '0; m_lo = '0;
      checks += 2;
      if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", op_ready); end
      if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_hilo: got %h want 0", {hi, lo}); end
      repeat (40) begin @(posedge Clk); #1; end
      checks++;
      if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_late: got %h want 0", {hi, lo}); end
   endtask

   task automatic test_random();
      int busy;
      logic [2:0] op;
      logic [31:0] a, b;
      logic [63:0] e;
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
         e = ref_hilo(op, a, b, {m_hi, m_lo});
         if (op == C_MFHI || op == C_MFLO) begin
            op_valid = 1'b1; op_code = op; #1;
            checks++;
            if (mf_data !== ((op == C_MFHI) ? m_hi : m_lo)) begin
               errors++; $display("FAIL rand_mf[%0d]: got %h want %h", i, mf_data, (op == C_MFHI) ? m_hi : m_lo);
            end
            @(posedge Clk); #1;
            op_valid = 1'b0;
         end else begin
            issue(op, a, b);
            if ((op == C_MADD || op == C_MSUB) && !MADD_EN) begin
               checks++;
               if (illegal_op !== 1'b1) begin errors++; $display("FAIL rand_illegal[%0d]: got %b want 1", i, illegal_op); end
            end else if (op <= C_MSUB) begin
               wait_ready(busy);
               checks++;
               if (busy != 33) begin errors++; $display("FAIL rand_busy[%0d]: got %0d want 33", i, busy); end
            end
            checks++;
            if ({hi, lo} !== e) begin
               errors++; $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, {hi, lo}, e);
            end
         end
         {m_hi, m_lo} = e;
      end
   endtask

   task automatic test_bpc4();
      int busy;
      logic [31:0] a, b;
      logic [63:0] e;
      for (int k = 0; k < 2; k++) begin
         a = (k == 0) ? 32'hFFFFFFFF : $urandom;
         b = (k == 0) ? 32'h00000002 : $urandom;
         c4 = (k == 0) ? C_MULT : C_MULTU;
         e = ref_hilo(c4, a, b, 64'h0);
         v4 = 1'b1; a4 = a; b4 = b;
         @(posedge Clk); #1;
         v4 = 1'b0;
         busy = 0;
         while (!rdy4 && busy < 200) begin @(posedge Clk); #1; busy++; end
         checks += 2;
         if (busy != 9) begin errors++; $display("FAIL bpc4_busy[%0d]: got %0d want 9", k, busy); end
         if ({hi4, lo4} !== e) begin errors++; $display("FAIL bpc4_hilo[%0d]: got %h want %h", k, {hi4, lo4}, e); end
      end
      checks++;
      if ({hi4, lo4} === 64'hFFFFFFFF_FFFFFFFE) begin
         errors++; $display("FAIL bpc4_second_op: got %h want new product", {hi4, lo4});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge Clk);
      #1 Reset_n = 1'b1;
      test_reset();
      test_multu();
      test_mult_signed();
      test_madd();
      test_back_to_back();
      test_flush();
      test_reset_mid_mul();
      test_random();
      test_bpc4();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
